// File: rtl/bsg_link_oserdes_phy.sv
// bsg_link_oserdes_phy
// Output serializer for the link PHY. Each accepted word of ratio_p*width_p
// bits is sent as ratio_p width_p-bit slices, one slice per clk_i cycle.
// A forwarded clock toggles every cycle once the block is out of reset.
// Consecutive words are streamed back to back: the next word is taken on
// the edge that emits the last slice of the current one.
// The optional macro BSG_LINK_OSERDES_PARITY_EN adds a registered
// even-parity output, parity_r_o, that accompanies each slice.

module bsg_link_oserdes_phy #(
  parameter int width_p     = 16,
  parameter int ratio_p     = 2,
  parameter int lsb_first_p = 1
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       valid_i,
  input  logic [ratio_p*width_p-1:0] data_i,
  output logic                       ready_o,
  output logic                       valid_r_o,
  output logic [width_p-1:0]         data_r_o,
  output logic                       clk_r_o
`ifdef BSG_LINK_OSERDES_PARITY_EN
  ,
  output logic                       parity_r_o
`endif
);

  // Reject configurations that cannot be serialized.
  if (ratio_p < 2) begin : g_bad_ratio
    $error("bsg_link_oserdes_phy: ratio_p must be >= 2");
  end
  if (width_p < 1) begin : g_bad_width
    $error("bsg_link_oserdes_phy: width_p must be >= 1");
  end

  localparam int                 cnt_w    = $clog2(ratio_p);
  localparam logic [cnt_w-1:0]   last_cnt = cnt_w'(ratio_p - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e                     state_r;
  logic                       live_r;
  logic [cnt_w-1:0]           cnt_r;
  logic [ratio_p*width_p-1:0] hold_r;
  logic [cnt_w-1:0]           slice_idx;
  logic [width_p-1:0]         cur_slice;
  logic                       accept;

  // The handshake depends only on registers, so upstream sees no
  // combinational path from valid_i back to ready_o.
  assign ready_o = live_r & ((state_r == IDLE) | (cnt_r == last_cnt));
  assign accept  = valid_i & ready_o;

  // Pick the slice for the current count, honouring the slice order.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; that is what keeps synthesis from inferring a latch.
    slice_idx = cnt_r;
    cur_slice = '0;
    if (lsb_first_p == 0) begin
      slice_idx = last_cnt - cnt_r;
    end
    for (int k = 0; k < ratio_p; k++) begin
      if (slice_idx == cnt_w'(k)) begin
        cur_slice = hold_r[k*width_p +: width_p];
      end
    end
  end

  // Liveness flag and forwarded clock: the clock runs only once live.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      live_r  <= 1'b0;
      clk_r_o <= 1'b0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every flop samples the pre-edge value of every other flop.
      live_r <= 1'b1;
      if (live_r) begin
        clk_r_o <= ~clk_r_o;
      end
    end
  end

  // Serializer state machine with registered slice outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      // NOTE: the hold register is a plain flop bank, not a memory, so it
      // takes the async reset along with the control state; a reset mid-word
      // therefore leaves nothing stale behind.
      state_r    <= IDLE;
      cnt_r      <= '0;
      hold_r     <= '0;
      valid_r_o  <= 1'b0;
      data_r_o   <= '0;
`ifdef BSG_LINK_OSERDES_PARITY_EN
      parity_r_o <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          valid_r_o  <= 1'b0;
          data_r_o   <= '0;
`ifdef BSG_LINK_OSERDES_PARITY_EN
          parity_r_o <= 1'b0;
`endif
          if (accept) begin
            hold_r  <= data_i;
            cnt_r   <= '0;
            state_r <= SHIFT;
          end
        end
        SHIFT: begin
          valid_r_o  <= 1'b1;
          data_r_o   <= cur_slice;
`ifdef BSG_LINK_OSERDES_PARITY_EN
          parity_r_o <= ^cur_slice;
`endif
          if (cnt_r == last_cnt) begin
            // Last slice leaves now; chain straight into the next word if
            // one is offered, otherwise drop back to idle.
            cnt_r <= '0;
            if (accept) begin
              hold_r <= data_i;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_link_oserdes_phy.sv
// Self-checking bench for bsg_link_oserdes_phy. Three instances cover
// ratio 2 / width 16 / LSB-first, ratio 4 / width 16 / LSB-first and
// ratio 3 / width 8 / MSB-first. Each is exercised in turn against a
// queue-based reference model: an accepted word pushes its slices in
// emission order, each live edge pops one slice onto the output, and the
// block is ready whenever at most one slice is still waiting.

module tb_bsg_link_oserdes_phy;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n0, rst_n1, rst_n2;
  logic        valid0, valid1, valid2;
  logic [31:0] data0;
  logic [63:0] data1;
  logic [23:0] data2;
  logic        ready0, ready1, ready2;
  logic        vr0, vr1, vr2;
  logic [15:0] dr0, dr1;
  logic [7:0]  dr2;
  logic        cr0, cr1, cr2;
`ifdef BSG_LINK_OSERDES_PARITY_EN
  logic        pr0, pr1, pr2;
`endif

  bsg_link_oserdes_phy #(.width_p(16), .ratio_p(2), .lsb_first_p(1)) u0 (
    .clk_i(clk), .reset_n_i(rst_n0), .valid_i(valid0), .data_i(data0),
    .ready_o(ready0), .valid_r_o(vr0), .data_r_o(dr0), .clk_r_o(cr0)
`ifdef BSG_LINK_OSERDES_PARITY_EN
    , .parity_r_o(pr0)
`endif
  );

  bsg_link_oserdes_phy #(.width_p(16), .ratio_p(4), .lsb_first_p(1)) u1 (
    .clk_i(clk), .reset_n_i(rst_n1), .valid_i(valid1), .data_i(data1),
    .ready_o(ready1), .valid_r_o(vr1), .data_r_o(dr1), .clk_r_o(cr1)
`ifdef BSG_LINK_OSERDES_PARITY_EN
    , .parity_r_o(pr1)
`endif
  );

  bsg_link_oserdes_phy #(.width_p(8), .ratio_p(3), .lsb_first_p(0)) u2 (
    .clk_i(clk), .reset_n_i(rst_n2), .valid_i(valid2), .data_i(data2),
    .ready_o(ready2), .valid_r_o(vr2), .data_r_o(dr2), .clk_r_o(cr2)
`ifdef BSG_LINK_OSERDES_PARITY_EN
    , .parity_r_o(pr2)
`endif
  );

  int checks = 0;
  int errors = 0;

  int cfg_w   [3] = '{16, 16, 8};
  int cfg_r   [3] = '{2, 4, 3};
  int cfg_lsb [3] = '{1, 1, 0};

  // Reference model for the instance currently under test.
  logic [15:0] exp_q[$];
  bit          rst_m  = 1'b1;
  bit          live_m = 1'b0;
  bit          clk_m  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int u, input logic v, input logic [63:0] d);
    case (u)
      0: begin valid0 = v; data0 = d[31:0]; end
      1: begin valid1 = v; data1 = d;       end
      default: begin valid2 = v; data2 = d[23:0]; end
    endcase
  endtask

  task automatic set_rst(input int u, input logic r);
    case (u)
      0: rst_n0 = r;
      1: rst_n1 = r;
      default: rst_n2 = r;
    endcase
  endtask

  task automatic get_obs(input int u, output logic r, output logic v,
                         output logic c, output logic [15:0] d, output logic p);
    p = 1'b0;
    case (u)
      0: begin
        r = ready0; v = vr0; c = cr0; d = dr0;
`ifdef BSG_LINK_OSERDES_PARITY_EN
        p = pr0;
`endif
      end
      1: begin
        r = ready1; v = vr1; c = cr1; d = dr1;
`ifdef BSG_LINK_OSERDES_PARITY_EN
        p = pr1;
`endif
      end
      default: begin
        r = ready2; v = vr2; c = cr2; d = {8'h00, dr2};
`ifdef BSG_LINK_OSERDES_PARITY_EN
        p = pr2;
`endif
      end
    endcase
  endtask

  task automatic check_outs(input int u, input string tag, input logic ev, input logic [15:0] ed);
    logic r, v, c, p;
    logic [15:0] d;
    get_obs(u, r, v, c, d, p);
    check({tag, ".ready"}, r, live_m && (exp_q.size() <= 1));
    check({tag, ".valid"}, v, ev);
    check({tag, ".data"},  d, ed);
    check({tag, ".clk"},   c, clk_m);
`ifdef BSG_LINK_OSERDES_PARITY_EN
    check({tag, ".parity"}, p, ev ? ^ed : 1'b0);
`else
    if (p !== 1'b0) check({tag, ".parity_absent"}, p, 1'b0);
`endif
  endtask

  // One clock cycle: drive inputs, advance the model across the edge, check.
  task automatic cycle(input int u, input logic v, input logic [63:0] d, input string tag);
    bit          acc;
    logic        ev;
    logic [15:0] ed;
    logic [63:0] mask;
    int          idx;
    set_in(u, v, d);
    acc = v && !rst_m && live_m && (exp_q.size() <= 1);
    @(posedge clk);
    ev = 1'b0;
    ed = '0;
    if (!rst_m) begin
      if (live_m) clk_m = ~clk_m;
      live_m = 1'b1;
      if (exp_q.size() > 0) begin
        ev = 1'b1;
        ed = exp_q.pop_front();
      end
      if (acc) begin
        mask = (64'd1 << cfg_w[u]) - 64'd1;
        for (int k = 0; k < cfg_r[u]; k++) begin
          idx = (cfg_lsb[u] != 0) ? k : cfg_r[u] - 1 - k;
          exp_q.push_back(16'((d >> (idx * cfg_w[u])) & mask));
        end
      end
    end
    #1;
    check_outs(u, tag, ev, ed);
  endtask

  task automatic reset_on(input int u, input string tag);
    set_rst(u, 1'b0);
    rst_m  = 1'b1;
    live_m = 1'b0;
    clk_m  = 1'b0;
    exp_q.delete();
    #1;
    check_outs(u, tag, 1'b0, 16'h0000);
  endtask

  task automatic reset_off(input int u);
    set_rst(u, 1'b1);
    rst_m = 1'b0;
  endtask

  initial begin
    rst_n0 = 1'b0; rst_n1 = 1'b0; rst_n2 = 1'b0;
    valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
    data0  = '0;   data1  = '0;   data2  = '0;
    #1;

    // ---- instance 0: ratio 2, width 16, LSB first ----
    reset_on(0, "u0_rst");
    repeat (3) cycle(0, 1'b1, 64'hDEAD_BEEF, "u0_rst_hold");
    reset_off(0);
    cycle(0, 1'b0, 64'h0, "u0_release");
    check("u0_ready_after_release", ready0, 1'b1);

    cycle(0, 1'b1, 64'hDEAD_BEEF, "u0_accept");
    cycle(0, 1'b0, 64'h0, "u0_s0");
    check("u0_lit_beef", {vr0, dr0}, {1'b1, 16'hBEEF});
    cycle(0, 1'b0, 64'h0, "u0_s1");
    check("u0_lit_dead", {vr0, dr0}, {1'b1, 16'hDEAD});
    cycle(0, 1'b0, 64'h0, "u0_idle");
    check("u0_lit_idle", {vr0, dr0}, {1'b0, 16'h0000});
    cycle(0, 1'b0, 64'h0, "u0_idle2");

`ifdef BSG_LINK_OSERDES_PARITY_EN
    cycle(0, 1'b1, 64'h0003_0001, "u0_par_accept");
    cycle(0, 1'b0, 64'h0, "u0_par_s0");
    check("u0_par_odd", pr0, 1'b1);
    cycle(0, 1'b0, 64'h0, "u0_par_s1");
    check("u0_par_even", pr0, 1'b0);
    cycle(0, 1'b0, 64'h0, "u0_par_idle");
    check("u0_par_idle_zero", pr0, 1'b0);
`endif

    repeat (60) cycle(0, 1'($urandom_range(0, 1)), {$urandom, $urandom}, "u0_rand");

    // ---- instance 1: ratio 4, width 16, LSB first ----
    reset_on(1, "u1_rst");
    cycle(1, 1'b0, 64'h0, "u1_rst_hold");
    reset_off(1);
    cycle(1, 1'b0, 64'h0, "u1_release");

    // Back-to-back: A is taken at once, B stalls until A's last slice.
    cycle(1, 1'b1, 64'hA3A3_A2A2_A1A1_A0A0, "u1_b2b_a");
    repeat (4) cycle(1, 1'b1, 64'hB3B3_B2B2_B1B1_B0B0, "u1_b2b_b");
    check("u1_lit_b2b_a3", dr1, 16'hA3A3);
    repeat (4) cycle(1, 1'b0, 64'h0, "u1_b2b_drain");
    check("u1_lit_b2b_b3", dr1, 16'hB3B3);
    repeat (2) cycle(1, 1'b0, 64'h0, "u1_b2b_idle");

    // Reset while slice 1 of 4 is on the line.
    cycle(1, 1'b1, 64'h4444_3333_2222_1111, "u1_mid_accept");
    cycle(1, 1'b0, 64'h0, "u1_mid_s0");
    cycle(1, 1'b0, 64'h0, "u1_mid_s1");
    check("u1_lit_mid_s1", dr1, 16'h2222);
    reset_on(1, "u1_mid_rst");
    cycle(1, 1'b0, 64'h0, "u1_mid_hold");
    reset_off(1);
    cycle(1, 1'b0, 64'h0, "u1_mid_release");
    cycle(1, 1'b1, 64'hC3C3_C2C2_C1C1_C0C0, "u1_c_accept");
    cycle(1, 1'b0, 64'h0, "u1_c_s0");
    check("u1_lit_c0", {vr1, dr1}, {1'b1, 16'hC0C0});
    repeat (5) cycle(1, 1'b0, 64'h0, "u1_c_drain");

    repeat (80) cycle(1, 1'($urandom_range(0, 1)), {$urandom, $urandom}, "u1_rand");

    // ---- instance 2: ratio 3, width 8, MSB first ----
    reset_on(2, "u2_rst");
    cycle(2, 1'b0, 64'h0, "u2_rst_hold");
    reset_off(2);
    cycle(2, 1'b0, 64'h0, "u2_release");

    repeat (2) cycle(2, 1'b0, 64'h11_2233, "u2_stall");
    cycle(2, 1'b1, 64'h11_2233, "u2_accept");
    cycle(2, 1'b0, 64'h0, "u2_s0");
    check("u2_lit_11", dr2, 8'h11);
    cycle(2, 1'b0, 64'h0, "u2_s1");
    check("u2_lit_22", dr2, 8'h22);
    cycle(2, 1'b0, 64'h0, "u2_s2");
    check("u2_lit_33", dr2, 8'h33);
    repeat (2) cycle(2, 1'b0, 64'h0, "u2_idle");

    repeat (80) cycle(2, 1'($urandom_range(0, 1)), {$urandom, $urandom}, "u2_rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
